// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller for the NCO phase increment: steps a tuning word
// from f_start to f_stop with a programmable dwell, single pass or continuous triangle.
module nco_sweep_ctrl #(
    parameter int PHI_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clken,
    input  logic               start,
    input  logic               stop,
    input  logic [PHI_W-1:0]   f_start,
    input  logic [PHI_W-1:0]   f_stop,
    input  logic [PHI_W-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mode,
    output logic [PHI_W-1:0]   phi_inc_o,
    output logic               busy,
    output logic               step_stb,
    output logic               sweep_done
);

    typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

    state_t             r_state,   w_state;
    logic [PHI_W-1:0]   r_phi,     w_phi;
    logic [DWELL_W-1:0] r_cnt,     w_cnt;
    logic               r_busy,    w_busy;
    logic               r_stb,     w_stb;
    logic               r_done,    w_done;
    logic [PHI_W-1:0]   r_f_start, w_f_start;
    logic [PHI_W-1:0]   r_f_stop,  w_f_stop;
    logic [PHI_W-1:0]   r_f_step,  w_f_step;
    logic [DWELL_W-1:0] r_dwell,   w_dwell;
    logic               r_mode,    w_mode;
    logic               r_dir,     w_dir;     // 1 = sweeping down
    logic [PHI_W-1:0]   r_tgt,     w_tgt;
    logic [PHI_W-1:0]   w_tgt_swap;

    // One step toward tgt, computed one bit wider so the word clamps instead of wrapping.
    function automatic logic [PHI_W-1:0] next_word(
        input logic [PHI_W-1:0] phi,
        input logic [PHI_W-1:0] tgt,
        input logic [PHI_W-1:0] stp,
        input logic             down
    );
        logic [PHI_W:0]   sum;
        logic [PHI_W-1:0] res;
        if (down) begin
            sum = {1'b0, phi} - {1'b0, stp};
            res = (sum[PHI_W] || (sum[PHI_W-1:0] <= tgt)) ? tgt : sum[PHI_W-1:0];
        end else begin
            sum = {1'b0, phi} + {1'b0, stp};
            res = (sum >= {1'b0, tgt}) ? tgt : sum[PHI_W-1:0];
        end
        return res;
    endfunction

    assign w_tgt_swap = (r_tgt == r_f_stop) ? r_f_start : r_f_stop;

    always_comb begin
        w_state   = r_state;
        w_phi     = r_phi;
        w_cnt     = r_cnt;
        w_busy    = r_busy;
        w_stb     = 1'b0;
        w_done    = 1'b0;
        w_f_start = r_f_start;
        w_f_stop  = r_f_stop;
        w_f_step  = r_f_step;
        w_dwell   = r_dwell;
        w_mode    = r_mode;
        w_dir     = r_dir;
        w_tgt     = r_tgt;
        if (stop) begin
            w_state = IDLE;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_f_start = f_start;
                        w_f_stop  = f_stop;
                        w_f_step  = f_step;
                        w_dwell   = dwell;
                        w_mode    = mode;
                        w_dir     = (f_stop < f_start);
                        w_tgt     = f_stop;
                        w_phi     = f_start;
                        w_cnt     = dwell;
                        w_busy    = 1'b1;
                        w_stb     = 1'b1;
                        w_state   = DWELL;
                    end
                end
                DWELL: begin
                    if (r_cnt != '0) begin
                        w_cnt = r_cnt - 1'b1;
                    end else if (r_phi != r_tgt) begin
                        w_phi = next_word(r_phi, r_tgt, r_f_step, r_dir);
                        w_cnt = r_dwell;
                        w_stb = 1'b1;
                    end else if (!r_mode) begin
                        w_state = IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else if (r_f_start != r_f_stop) begin
                        // Triangle turn-around: new endpoint and first step in the same edge.
                        w_tgt = w_tgt_swap;
                        w_dir = ~r_dir;
                        w_phi = next_word(r_phi, w_tgt_swap, r_f_step, ~r_dir);
                        w_cnt = r_dwell;
                        w_stb = 1'b1;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_phi     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_stb     <= 1'b0;
            r_done    <= 1'b0;
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
            r_mode    <= 1'b0;
            r_dir     <= 1'b0;
            r_tgt     <= '0;
        end else if (clken) begin
            r_state   <= w_state;
            r_phi     <= w_phi;
            r_cnt     <= w_cnt;
            r_busy    <= w_busy;
            r_stb     <= w_stb;
            r_done    <= w_done;
            r_f_start <= w_f_start;
            r_f_stop  <= w_f_stop;
            r_f_step  <= w_f_step;
            r_dwell   <= w_dwell;
            r_mode    <= w_mode;
            r_dir     <= w_dir;
            r_tgt     <= w_tgt;
        end
    end

    assign phi_inc_o  = r_phi;
    assign busy       = r_busy;
    assign step_stb   = r_stb;
    assign sweep_done = r_done;

endmodule
